// File: rtl/mdu_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
//   op_e    : funct3 operation encoding
//   state_e : sequencer states
//   is_div / is_rem : operation class decode
package mdu_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        SPECIAL = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_sign_prep.sv
// Operand preparation for the multiply/divide unit (combinational).
// Ports:
//   op        : funct3 operation
//   A, B      : raw operands (rs1, rs2)
//   a_mag     : |A| when A is treated as signed for this op, else A
//   b_mag     : |B| when B is treated as signed for this op, else B
//   neg       : final result must be two's-complement negated
//   div_zero  : divide/remainder with B == 0
//   ovf       : signed DIV/REM of most-negative by -1
module mdu_sign_prep
    import mdu_pkg::*;
#(
    parameter int unsigned dataW = 32
) (
    input  logic [2:0]       op,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic [dataW-1:0] a_mag,
    output logic [dataW-1:0] b_mag,
    output logic             neg,
    output logic             div_zero,
    output logic             ovf
);

    localparam logic [dataW-1:0] MOST_NEG = {1'b1, {(dataW-1){1'b0}}};

    op_e  op_t;
    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    // Signedness per op, magnitudes and the result sign
    always_comb begin
        op_t     = op_e'(op);
        a_signed = (op_t == MULH) || (op_t == MULHSU) || (op_t == DIV) || (op_t == REM);
        b_signed = (op_t == MULH) || (op_t == DIV) || (op_t == REM);
        a_neg    = a_signed & A[dataW-1];
        b_neg    = b_signed & B[dataW-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        // Remainder follows the dividend; everything else is sign(A)^sign(B)
        neg      = is_rem(op) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(op) && (B == '0);
        ovf      = ((op_t == DIV) || (op_t == REM)) && (A == MOST_NEG) && (B == '1);
    end

endmodule

// File: rtl/mdu_r32m.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, valid/ready on both sides.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high only when idle)
//   op, A, B             : funct3 op and operands, sampled at accept only
//   out_valid/out_ready  : result handshake; result held until accepted
//   result               : dataW-bit result
// Build option: define MDU_FAST_MUL_EN to compute multiplies with a
// single-cycle combinational product through the SPECIAL state.
module mdu_r32m
    import mdu_pkg::*;
#(
    parameter int unsigned dataW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataW-1:0] result
);

    localparam int unsigned cntW  = $clog2(dataW) + 1;
    localparam int unsigned prodW = 2 * dataW;

    state_e           state, state_n;
    logic [cntW-1:0]  cnt, cnt_n;
    logic [dataW-1:0] acc, acc_n;    // product high half / partial remainder
    logic [dataW-1:0] lo, lo_n;      // multiplier->product low / dividend->quotient
    logic [dataW-1:0] m, m_n;        // multiplicand / divisor magnitude
    op_e              op_q, op_q_n;
    logic             neg_q, neg_n;
    logic [dataW-1:0] result_n;
    logic             out_valid_n;
    logic             in_ready_n;

    logic [dataW-1:0] a_mag, b_mag;
    logic             p_neg, p_dz, p_ovf;

    logic [dataW:0]   sum;
    logic [dataW:0]   shifted;
    logic [dataW:0]   diff;
    logic [dataW-1:0] acc_it, lo_it;
    logic [dataW-1:0] calc_res;

    mdu_sign_prep #(.dataW(dataW)) u_sign_prep (
        .op       (op),
        .A        (A),
        .B        (B),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .neg      (p_neg),
        .div_zero (p_dz),
        .ovf      (p_ovf)
    );

    // Sign fix-up and half selection applied to a finished magnitude result
    function automatic logic [dataW-1:0] fixup(
        input op_e              o,
        input logic             n,
        input logic [prodW-1:0] prod,
        input logic [dataW-1:0] quo,
        input logic [dataW-1:0] rem
    );
        logic [prodW-1:0] p;
        p = n ? -prod : prod;
        if (is_div(o)) begin
            if (is_rem(o)) return n ? -rem : rem;
            else           return n ? -quo : quo;
        end
        if (o == MUL) return p[dataW-1:0];
        return p[prodW-1:dataW];
    endfunction

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        sum     = {1'b0, acc} + (lo[0] ? {1'b0, m} : '0);
        shifted = {acc, lo[dataW-1]};
        diff    = shifted - {1'b0, m};
        if (is_div(op_q)) begin
            if (!diff[dataW]) begin
                acc_it = diff[dataW-1:0];
                lo_it  = {lo[dataW-2:0], 1'b1};
            end else begin
                acc_it = shifted[dataW-1:0];
                lo_it  = {lo[dataW-2:0], 1'b0};
            end
        end else begin
            acc_it = sum[dataW:1];
            lo_it  = {sum[0], lo[dataW-1:1]};
        end
        calc_res = fixup(op_q, neg_q, {acc_it, lo_it}, lo_it, acc_it);
    end

`ifdef MDU_FAST_MUL_EN
    logic [prodW-1:0] prod_fast;
    logic [dataW-1:0] fast_res;

    // Single-cycle product of the latched magnitudes
    always_comb begin
        prod_fast = prodW'(m) * prodW'(lo);
        fast_res  = fixup(op_q, neg_q, prod_fast, lo, lo);
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        lo_n     = lo;
        m_n      = m;
        op_q_n   = op_q;
        neg_n    = neg_q;
        result_n = result;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_q_n = op_e'(op);
                    neg_n  = p_neg;
                    cnt_n  = '0;
                    acc_n  = '0;
                    // Special-case results are parked in lo for the SPECIAL load
                    if (p_dz) begin
                        lo_n    = is_rem(op) ? A : '1;
                        state_n = SPECIAL;
                    end else if (p_ovf) begin
                        lo_n    = is_rem(op) ? '0 : A;
                        state_n = SPECIAL;
                    end else begin
                        m_n  = is_div(op) ? b_mag : a_mag;
                        lo_n = is_div(op) ? a_mag : b_mag;
`ifdef MDU_FAST_MUL_EN
                        state_n = is_div(op) ? CALC : SPECIAL;
`else
                        state_n = CALC;
`endif
                    end
                end
            end
            CALC: begin
                acc_n = acc_it;
                lo_n  = lo_it;
                cnt_n = cnt + cntW'(1);
                if (cnt == cntW'(dataW - 1)) begin
                    result_n = calc_res;
                    state_n  = DONE;
                end
            end
            SPECIAL: begin
`ifdef MDU_FAST_MUL_EN
                result_n = is_div(op_q) ? lo : fast_res;
`else
                result_n = lo;
`endif
                state_n = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // out_valid rises the cycle after DONE is entered, once result is settled
        out_valid_n = (state == DONE) && !(out_valid && out_ready);
        in_ready_n  = (state_n == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            lo        <= '0;
            m         <= '0;
            op_q      <= MUL;
            neg_q     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            lo        <= lo_n;
            m         <= m_n;
            op_q      <= op_q_n;
            neg_q     <= neg_n;
            result    <= result_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
        end
    end

endmodule

// File: tb/tb_mdu_r32m.sv
// Self-checking bench for mdu_r32m: directed test-plan vectors, backpressure,
// input isolation, mid-operation reset and randomized ops against a
// plain-arithmetic reference model.
module tb_mdu_r32m;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_r32m #(.dataW(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference result from the RV32M arithmetic rules
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0)) return 2;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MDU_FAST_MUL_EN
        if (!o[2]) return 2;
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, then scramble inputs; returns result and accept-to-valid latency
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit overlap, output bit timeout);
        int guard;
        overlap = 1'b0;
        timeout = 1'b0;
        lat     = 0;
        guard   = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timeout = 1'b1;
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A  = $urandom;
        B  = $urandom;
        op = 3'($urandom_range(0, 7));
        if (in_ready) overlap = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) overlap = 1'b1;
        end while (!out_valid && lat < 200);
        if (!out_valid) timeout = 1'b1;
        res = result;
    endtask

    task automatic finish_op(output logic ov, output logic ir);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        ov = out_valid;
        ir = in_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  vo [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd5, 3'd7, 3'd4, 3'd4, 3'd6, 3'd6};
        logic [31:0] va [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100,
                                 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] vb [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd2, 32'd7,
                                 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ve [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd5};
        logic [31:0] res;
        int          lat;
        bit          ovl, tmo;
        logic        ov, ir;
        for (int i = 0; i < 14; i++) begin
            issue(vo[i], va[i], vb[i], res, lat, ovl, tmo);
            n_checks++; if (res !== ve[i]) begin n_fail++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, ve[i]); end
            n_checks++; if (lat != ref_latency(vo[i], va[i], vb[i])) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, ref_latency(vo[i], va[i], vb[i])); end
            n_checks++; if (ovl || tmo) begin n_fail++; $display("FAIL directed_%0d_handshake: overlap %b timeout %b expected 0 0", i, ovl, tmo); end
            finish_op(ov, ir);
            n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_fail++; $display("FAIL directed_%0d_release: out_valid %b in_ready %b expected 0 1", i, ov, ir); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        bit          ovl, tmo;
        logic        ov, ir;
        issue(3'd5, 32'd1000, 32'd7, res, lat, ovl, tmo);
        n_checks++; if (res !== 32'd142 || tmo) begin n_fail++; $display("FAIL bp_result: got %h expected %h", res, 32'd142); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd142) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: out_valid %b in_ready %b result %h expected 1 0 %h", i, out_valid, in_ready, result, 32'd142);
            end
        end
        finish_op(ov, ir);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_fail++; $display("FAIL bp_release: out_valid %b in_ready %b expected 0 1", ov, ir); end
    endtask

    // Inputs and in_valid toggle during CALC; only the accepted op counts
    task automatic test_input_change();
        int   guard;
        logic ov, ir;
        @(negedge clk);
        op = 3'd4; A = 32'd1000; B = 32'hFFFF_FFF9; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7)); in_valid = 1'b1;
        end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FF72) begin n_fail++; $display("FAIL input_change_result: out_valid %b result %h expected 1 %h", out_valid, result, 32'hFFFF_FF72); end
        finish_op(ov, ir);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_fail++; $display("FAIL input_change_release: out_valid %b in_ready %b expected 0 1", ov, ir); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL input_change_idle: in_ready %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int          lat;
        bit          ovl, tmo;
        logic        ov, ir;
        @(negedge clk);
        op = 3'd3; A = 32'hDEAD_BEEF; B = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", result); end
        @(negedge clk);
        reset = 1'b0;
        issue(3'd0, 32'd3, 32'd4, res, lat, ovl, tmo);
        n_checks++; if (res !== 32'd12 || tmo) begin n_fail++; $display("FAIL midreset_mul: got %h expected %h", res, 32'd12); end
        n_checks++; if (lat != ref_latency(3'd0, 32'd3, 32'd4)) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", lat, ref_latency(3'd0, 32'd3, 32'd4)); end
        finish_op(ov, ir);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, res, exp;
        int          lat, d;
        bit          ovl, tmo;
        logic        ov, ir;
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = ref_model(o, a, b);
            issue(o, a, b, res, lat, ovl, tmo);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random_%0d_op%0d_result: got %h expected %h (a=%h b=%h)", i, o, res, exp, a, b); end
            n_checks++; if (lat != ref_latency(o, a, b) || ovl || tmo) begin n_fail++; $display("FAIL random_%0d_timing: latency %0d overlap %b timeout %b expected %0d 0 0", i, lat, ovl, tmo, ref_latency(o, a, b)); end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            n_checks++; if (result !== exp || out_valid !== 1'b1) begin n_fail++; $display("FAIL random_%0d_hold: out_valid %b result %h expected 1 %h", i, out_valid, result, exp); end
            finish_op(ov, ir);
            n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin n_fail++; $display("FAIL random_%0d_release: out_valid %b in_ready %b expected 0 1", i, ov, ir); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_input_change();
        test_reset_mid_calc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
